fpa_operand_feeder: RTL

//  Upstream input-sequencer stage for the FP16 (IEEE754 half) adder. Implements the "Input 1 -> Input 2 -> CALC" flow:
//  - accepts two operands as consecutive 16-bit words on a valid/ready stream;
//  - drives Finput1/Finput2 and holds them stable while the 3-stage adder computes;
//  - samples FPSUM/ovf/unf into a result register;
//  - offers the result on a valid/ready output.

---
 rtl/fpa_pkg.sv | 22 ++
 rtl/fpa_calc_timer.sv | 34 +++
 rtl/fpa_operand_feeder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fpa_pkg.sv
// Shared definitions for the FP16 adder operand feeder.
// Holds the feeder state encoding, the FP16 field widths and a zero-magnitude helper.
package fpa_pkg;

  localparam int unsigned FP16_W     = 16;
  localparam int unsigned FP16_EXP_W = 5;
  localparam int unsigned FP16_MAN_W = 10;
  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    S_IN1  = 2'd0,
    S_IN2  = 2'd1,
    S_CALC = 2'd2,
    S_OUT  = 2'd3
  } fpa_state_e;

  // True for +0 and -0: exponent and mantissa both zero, sign ignored.
  function automatic logic fp16_is_zero(input logic [FP16_W-1:0] x);
    return (x[FP16_EXP_W+FP16_MAN_W-1:0] == '0);
  endfunction

endpackage

// File: rtl/fpa_calc_timer.sv
// Down-counter that times the adder's compute window.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   load_i    reload the counter with CYCLES-1
//   en_i      count down by one (saturates at zero)
//   done_o    counter has reached zero
module fpa_calc_timer #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Counter register; holds at zero so done stays asserted until reloaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CNT_W'(CYCLES - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/fpa_operand_feeder.sv
// Input sequencer for the 3-stage FP16 adder: collects two operand words,
// holds them on Finput1/Finput2 while the adder computes, captures the sum
// and flags, and offers them on a valid/ready result port.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in_data/in_valid/in_ready         operand word stream
//   Finput1, Finput2                  registered operands to the adder
//   FPSUM, ovf, unf                   adder result and flags
//   res_data/res_ovf/res_unf          captured result
//   res_valid/res_ready               result handshake
//   busy                              computing or holding a result
//   op_count                          completed transactions (wraps)
// Build option: FPA_ZERO_BYPASS_EN - a pair containing a zero operand skips
// the compute window and returns the other operand directly.
module fpa_operand_feeder
  import fpa_pkg::*;
#(
  parameter int unsigned CALC_CYCLES = 4,
  parameter int unsigned COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FP16_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [FP16_W-1:0]  Finput1,
  output logic [FP16_W-1:0]  Finput2,
  input  logic [FP16_W-1:0]  FPSUM,
  input  logic               ovf,
  input  logic               unf,
  output logic [FP16_W-1:0]  res_data,
  output logic               res_ovf,
  output logic               res_unf,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               busy,
  output logic [COUNT_W-1:0] op_count
);

  fpa_state_e         state_q;
  logic [FP16_W-1:0]  fin1_q, fin2_q, res_data_q;
  logic               res_ovf_q, res_unf_q, res_valid_q;
  logic [COUNT_W-1:0] op_count_q;
  logic               timer_load, timer_done;

  // The timer is armed on the second-operand capture edge.
  assign timer_load = (state_q == S_IN2) && in_valid;

  fpa_calc_timer #(.CYCLES(CALC_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (timer_load),
    .en_i   (state_q == S_CALC),
    .done_o (timer_done)
  );

`ifdef FPA_ZERO_BYPASS_EN
  logic a_zero, b_zero;
  assign a_zero = fp16_is_zero(fin1_q);
  assign b_zero = fp16_is_zero(in_data);
`endif

  // Sequencer FSM with its registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IN1;
      fin1_q      <= FP16_ZERO;
      fin2_q      <= FP16_ZERO;
      res_data_q  <= FP16_ZERO;
      res_ovf_q   <= 1'b0;
      res_unf_q   <= 1'b0;
      res_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        S_IN1: begin
          if (in_valid) begin
            fin1_q  <= in_data;
            state_q <= S_IN2;
          end
        end
        S_IN2: begin
          if (in_valid) begin
            fin2_q  <= in_data;
            state_q <= S_CALC;
`ifdef FPA_ZERO_BYPASS_EN
            if (a_zero || b_zero) begin
              // Both-zero collapses to +0 rather than either signed zero.
              if (a_zero && b_zero) begin
                res_data_q <= FP16_ZERO;
              end else if (a_zero) begin
                res_data_q <= in_data;
              end else begin
                res_data_q <= fin1_q;
              end
              res_ovf_q   <= 1'b0;
              res_unf_q   <= 1'b0;
              res_valid_q <= 1'b1;
              state_q     <= S_OUT;
            end
`endif
          end
        end
        S_CALC: begin
          if (timer_done) begin
            res_data_q  <= FPSUM;
            res_ovf_q   <= ovf;
            res_unf_q   <= unf;
            res_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end
        end
        S_OUT: begin
          if (res_valid_q && res_ready) begin
            res_valid_q <= 1'b0;
            op_count_q  <= op_count_q + COUNT_W'(1);
            state_q     <= S_IN1;
          end
        end
        default: state_q <= S_IN1;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IN1) || (state_q == S_IN2);
  assign busy      = (state_q == S_CALC) || (state_q == S_OUT);
  assign Finput1   = fin1_q;
  assign Finput2   = fin2_q;
  assign res_data  = res_data_q;
  assign res_ovf   = res_ovf_q;
  assign res_unf   = res_unf_q;
  assign res_valid = res_valid_q;
  assign op_count  = op_count_q;

endmodule
